// File: rtl/sm83_ext_bus_if.sv
// Bus bundle between the CPU IO stage / external pins and the sm83 external bus unit.
// The master side drives the IO-stage signals and the pin input value. The slave side is the bus unit.
interface sm83_ext_bus_if #(
   parameter int unsigned ADR_WIDTH = 16,
   parameter int unsigned WORD_SIZE = 8
);
   logic                 t1, t2, t3, t4;
   logic [ADR_WIDTH-1:0] cpu_adr;
   logic [WORD_SIZE-1:0] cpu_dout;
   logic                 cpu_n_rd, cpu_p_rd, cpu_n_wr, cpu_p_wr;
   logic [WORD_SIZE-1:0] cpu_din;
   logic [ADR_WIDTH-1:0] pin_a;
   logic [WORD_SIZE-1:0] pin_d_out;
   logic                 pin_d_oe;
   logic [WORD_SIZE-1:0] pin_d_in;
   logic                 pin_rd_n, pin_wr_n, pin_cs_n;
   logic [7:0]           oam_adr;
   logic [WORD_SIZE-1:0] oam_data;
   logic                 oam_we;
   logic                 dma_active;

   modport master (
      output t1, t2, t3, t4, cpu_adr, cpu_dout, cpu_n_rd, cpu_p_rd, cpu_n_wr, cpu_p_wr, pin_d_in,
      input  cpu_din, pin_a, pin_d_out, pin_d_oe, pin_rd_n, pin_wr_n, pin_cs_n,
             oam_adr, oam_data, oam_we, dma_active
   );

   modport slave (
      input  t1, t2, t3, t4, cpu_adr, cpu_dout, cpu_n_rd, cpu_p_rd, cpu_n_wr, cpu_p_wr, pin_d_in,
      output cpu_din, pin_a, pin_d_out, pin_d_oe, pin_rd_n, pin_wr_n, pin_cs_n,
             oam_adr, oam_data, oam_we, dma_active
   );
endinterface

// File: rtl/sm83_ext_bus.sv
// External bus unit: passes IO-stage accesses to the cartridge/WRAM pins, captures read data,
// and runs the OAM DMA engine that takes the bus over for DMA_LEN M-cycles.
module sm83_ext_bus #(
   parameter int unsigned          ADR_WIDTH   = 16,
   parameter int unsigned          WORD_SIZE   = 8,
   parameter int unsigned          DMA_LEN     = 160,
   parameter logic [ADR_WIDTH-1:0] DMA_REG_ADR = 16'hff46
) (
   input logic           clk,
   input logic           n_reset,
   sm83_ext_bus_if.slave bus
);
   localparam logic [ADR_WIDTH-1:0] INT_BASE  = ADR_WIDTH'(16'hfe00);
   localparam logic [ADR_WIDTH-1:0] CS_LO     = ADR_WIDTH'(16'ha000);
   localparam logic [ADR_WIDTH-1:0] CS_HI     = ADR_WIDTH'(16'hfdff);
   localparam logic [WORD_SIZE-1:0] REMAP_MIN = WORD_SIZE'(8'hfe);
   localparam logic [WORD_SIZE-1:0] REMAP_OFS = WORD_SIZE'(8'h20);
   localparam logic [7:0]           LAST_IDX  = 8'(DMA_LEN - 1);

   // StSnoop covers the rest of the M-cycle in which the source register was written,
   // so that StStart spans one whole M-cycle.
   typedef enum logic [1:0] {StIdle, StSnoop, StStart, StActive} state_e;

   state_e               state;
   logic [7:0]           idx;
   logic [WORD_SIZE-1:0] src_hi;
   logic [WORD_SIZE-1:0] cur_src;
   logic                 dma_rd;
   logic                 dma_active_q;
   logic [WORD_SIZE-1:0] cpu_din_q;
   logic [7:0]           oam_adr_q;
   logic [WORD_SIZE-1:0] oam_data_q;
   logic                 oam_we_q;
   logic [ADR_WIDTH-1:0] pin_a_q;

   logic                 ext;
   logic                 cpu_owns;
   logic                 snoop;
   logic [WORD_SIZE-1:0] snoop_src;
   logic [ADR_WIDTH-1:0] pin_a;
   logic                 pin_rd_n;
   logic                 pin_wr_n;
   logic                 pin_d_oe;

   assign ext       = bus.cpu_adr < INT_BASE;
   assign cpu_owns  = n_reset && !dma_active_q && ext;
   assign snoop     = bus.cpu_n_wr && bus.t3 && (bus.cpu_adr == DMA_REG_ADR);
   assign snoop_src = (bus.cpu_dout >= REMAP_MIN) ? bus.cpu_dout - REMAP_OFS : bus.cpu_dout;

   // dma_rd marks an M-cycle in which the engine reads a byte; it outlives a mid-cycle restart.
   always_comb begin
      pin_a    = pin_a_q;
      pin_rd_n = 1'b1;
      pin_wr_n = 1'b1;
      pin_d_oe = 1'b0;
      if (dma_rd) begin
         pin_a    = ADR_WIDTH'({cur_src, idx});
         pin_rd_n = 1'b0;
      end else if (cpu_owns) begin
         pin_a    = bus.cpu_adr;
         pin_rd_n = !bus.cpu_n_rd;
         pin_wr_n = !bus.cpu_n_wr;
         pin_d_oe = bus.cpu_p_wr;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state        <= StIdle;
         idx          <= '0;
         src_hi       <= '0;
         cur_src      <= '0;
         dma_rd       <= 1'b0;
         dma_active_q <= 1'b0;
         cpu_din_q    <= '1;
         oam_adr_q    <= '0;
         oam_data_q   <= '0;
         oam_we_q     <= 1'b0;
         pin_a_q      <= '0;
      end else begin
         pin_a_q  <= pin_a;
         oam_we_q <= 1'b0;
         if (bus.t3 && ext) begin
            cpu_din_q <= dma_active_q ? '1 : bus.pin_d_in;
         end
         if (snoop) begin
            src_hi <= snoop_src;
            state  <= StSnoop;
         end
         if (bus.t4) begin
            if (dma_rd) begin
               oam_we_q   <= 1'b1;
               oam_adr_q  <= idx;
               oam_data_q <= bus.pin_d_in;
            end
            dma_rd <= 1'b0;
            unique case (state)
               StIdle: begin
               end
               StSnoop: begin
                  state <= StStart;
               end
               StStart: begin
                  state        <= StActive;
                  idx          <= '0;
                  cur_src      <= src_hi;
                  dma_rd       <= 1'b1;
                  dma_active_q <= 1'b1;
               end
               StActive: begin
                  idx <= idx + 8'd1;
                  if (idx == LAST_IDX) begin
                     state        <= StIdle;
                     dma_active_q <= 1'b0;
                  end else begin
                     dma_rd <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.pin_a      = pin_a;
   assign bus.pin_rd_n   = pin_rd_n;
   assign bus.pin_wr_n   = pin_wr_n;
   assign bus.pin_d_oe   = pin_d_oe;
   assign bus.pin_d_out  = bus.cpu_dout;
   assign bus.pin_cs_n   = !((pin_a >= CS_LO) && (pin_a <= CS_HI) && (bus.t2 || bus.t3 || bus.t4));
   assign bus.cpu_din    = cpu_din_q;
   assign bus.oam_adr    = oam_adr_q;
   assign bus.oam_data   = oam_data_q;
   assign bus.oam_we     = oam_we_q;
   assign bus.dma_active = dma_active_q;
endmodule

// File: tb/tb_sm83_ext_bus.sv
// Randomised bench for sm83_ext_bus against an M-cycle level model of the bus and OAM DMA.
module tb_sm83_ext_bus;
   localparam int DmaLen = 160;
   localparam int KIdle  = 0;
   localparam int KStart = 1;
   localparam int KXfer  = 2;

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   sm83_ext_bus_if bus ();
   sm83_ext_bus dut (.clk(clk), .n_reset(n_reset), .bus(bus));

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: what each M-cycle is (idle/start/transfer) and what the DUT must show
   int          m_kind   = KIdle;
   bit          m_active = 1'b0;
   int          m_idx    = 0;
   logic [7:0]  m_src    = 8'h00;
   logic [7:0]  new_src  = 8'h00;
   bit          snoop    = 1'b0;
   logic [7:0]  m_din    = 8'hff;
   logic [15:0] last_a   = 16'h0000;
   bit          we_due   = 1'b0;
   logic [7:0]  we_adr, we_data;

   // Snapshots of DUT outputs per T-state, for the directed literal checks
   logic [15:0] s_a  [1:4];
   logic        s_rd [1:4];
   logic        s_wr [1:4];
   logic        s_oe [1:4];
   logic        s_cs [1:4];
   logic [7:0]  s_dout [1:4];
   logic        s_act;
   logic [7:0]  s_din4;
   int          oam_cnt = 0;
   logic [7:0]  oam_last = 8'h00;

   int          ph;
   bit          ext;
   logic [15:0] ea;
   logic        erd, ewr, eoe, ecs, ewe;

   always @(negedge clk) begin
      if (!n_reset) begin
         chk("rst_dma_active", 32'(bus.dma_active), 0);
         chk("rst_oam_we", 32'(bus.oam_we), 0);
         chk("rst_cpu_din", 32'(bus.cpu_din), 32'hff);
         chk("rst_pin_rd_n", 32'(bus.pin_rd_n), 1);
         chk("rst_pin_wr_n", 32'(bus.pin_wr_n), 1);
         chk("rst_pin_d_oe", 32'(bus.pin_d_oe), 0);
         chk("rst_pin_a", 32'(bus.pin_a), 0);
         m_kind = KIdle; m_active = 1'b0; m_idx = 0; m_din = 8'hff;
         last_a = 16'h0000; we_due = 1'b0; snoop = 1'b0;
      end else if (bus.t1 || bus.t2 || bus.t3 || bus.t4) begin
         ph  = bus.t1 ? 1 : bus.t2 ? 2 : bus.t3 ? 3 : 4;
         ext = bus.cpu_adr < 16'hfe00;
         if (m_kind == KXfer) begin
            ea = {m_src, 8'(m_idx)}; erd = 1'b0; ewr = 1'b1; eoe = 1'b0;
         end else if (m_active || !ext) begin
            ea = last_a; erd = 1'b1; ewr = 1'b1; eoe = 1'b0;
         end else begin
            ea = bus.cpu_adr; erd = !bus.cpu_n_rd; ewr = !bus.cpu_n_wr; eoe = bus.cpu_p_wr;
         end
         ecs = !(ea >= 16'ha000 && ea <= 16'hfdff && (bus.t2 || bus.t3 || bus.t4));
         ewe = bus.t1 && we_due;
         chk("pin_a", 32'(bus.pin_a), 32'(ea));
         chk("pin_rd_n", 32'(bus.pin_rd_n), 32'(erd));
         chk("pin_wr_n", 32'(bus.pin_wr_n), 32'(ewr));
         chk("pin_d_oe", 32'(bus.pin_d_oe), 32'(eoe));
         chk("pin_cs_n", 32'(bus.pin_cs_n), 32'(ecs));
         chk("pin_d_out", 32'(bus.pin_d_out), 32'(bus.cpu_dout));
         chk("dma_active", 32'(bus.dma_active), 32'(m_active));
         chk("cpu_din", 32'(bus.cpu_din), 32'(m_din));
         chk("oam_we", 32'(bus.oam_we), 32'(ewe));
         if (ewe) begin
            chk("oam_adr", 32'(bus.oam_adr), 32'(we_adr));
            chk("oam_data", 32'(bus.oam_data), 32'(we_data));
         end
         s_a[ph] = bus.pin_a; s_rd[ph] = bus.pin_rd_n; s_wr[ph] = bus.pin_wr_n;
         s_oe[ph] = bus.pin_d_oe; s_cs[ph] = bus.pin_cs_n; s_dout[ph] = bus.pin_d_out;
         if (ph == 1) s_act = bus.dma_active;
         if (ph == 4) s_din4 = bus.cpu_din;
         if (bus.oam_we) begin oam_cnt++; oam_last = bus.oam_adr; end
         // advance the model across the coming posedge
         last_a = ea;
         if (bus.t1) we_due = 1'b0;
         if (bus.t3 && ext) m_din = m_active ? 8'hff : bus.pin_d_in;
         if (bus.t3 && bus.cpu_n_wr && bus.cpu_adr == 16'hff46) begin
            snoop   = 1'b1;
            new_src = (bus.cpu_dout >= 8'hfe) ? bus.cpu_dout - 8'h20 : bus.cpu_dout;
         end
         if (bus.t4) begin
            if (m_kind == KXfer) begin
               we_due = 1'b1; we_adr = 8'(m_idx); we_data = bus.pin_d_in;
            end
            if (snoop) m_kind = KStart;
            else if (m_kind == KStart) begin
               m_kind = KXfer; m_idx = 0; m_src = new_src; m_active = 1'b1;
            end else if (m_kind == KXfer) begin
               if (m_idx == DmaLen - 1) begin m_kind = KIdle; m_active = 1'b0; end
               else m_idx++;
            end
            snoop = 1'b0;
         end
      end
   end

   // op: 0 none, 1 read, 2 write; din < 0 means random pin data
   task automatic mcycle(input int op, input logic [15:0] adr, input logic [7:0] dat, input int din);
      for (int p = 1; p <= 4; p++) begin
         bus.t1 = (p == 1); bus.t2 = (p == 2); bus.t3 = (p == 3); bus.t4 = (p == 4);
         bus.cpu_adr  = adr;
         bus.cpu_dout = dat;
         bus.cpu_n_rd = (op == 1) && (p <= 3);
         bus.cpu_p_rd = (op == 1);
         bus.cpu_p_wr = (op == 2) && (p == 2 || p == 3);
         bus.cpu_n_wr = (op == 2) && (p == 3);
         bus.pin_d_in = (din < 0) ? 8'($urandom) : 8'(din);
         @(posedge clk); #1;
      end
   endtask

   task automatic bus_quiet();
      bus.t1 = 0; bus.t2 = 0; bus.t3 = 0; bus.t4 = 0;
      bus.cpu_adr = 16'h0000; bus.cpu_dout = 8'h00; bus.pin_d_in = 8'h00;
      bus.cpu_n_rd = 0; bus.cpu_p_rd = 0; bus.cpu_n_wr = 0; bus.cpu_p_wr = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      int op, r;
      logic [15:0] adr;
      logic [7:0] dat;
      bus_quiet();
      n_reset = 1'b1;
      #1 n_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 n_reset = 1'b1;

      mcycle(1, 16'h0150, 8'h00, 32'h3c);
      chk("rd_pin_a", 32'(s_a[2]), 32'h0150);
      chk("rd_pin_rd_n", 32'(s_rd[2]), 0);
      chk("rd_pin_cs_n", 32'(s_cs[3]), 1);
      chk("rd_cpu_din_t4", 32'(s_din4), 32'h3c);

      mcycle(2, 16'hc000, 8'h5a, -1);
      chk("wr_wr_n_t2", 32'(s_wr[2]), 1);
      chk("wr_wr_n_t3", 32'(s_wr[3]), 0);
      chk("wr_oe_t2", 32'(s_oe[2]), 1);
      chk("wr_oe_t4", 32'(s_oe[4]), 0);
      chk("wr_d_out", 32'(s_dout[3]), 32'h5a);
      chk("wr_cs_t1", 32'(s_cs[1]), 1);
      chk("wr_cs_t2", 32'(s_cs[2]), 0);
      chk("wr_cs_t4", 32'(s_cs[4]), 0);

      mcycle(2, 16'hff46, 8'hc1, -1);
      oam_cnt = 0;
      mcycle(0, 16'h0000, 8'h00, -1);
      chk("start_dma_active", 32'(s_act), 0);
      for (int j = 0; j < DmaLen; j++) begin
         if (j == 10) mcycle(1, 16'h4000, 8'h00, -1);
         else if (j == 11) mcycle(1, 16'hff80, 8'h00, -1);
         else if (j == 12) mcycle(2, 16'h4000, 8'h77, -1);
         else mcycle(0, 16'h0000, 8'h00, -1);
         if (j == 0) begin
            chk("dma_first_adr", 32'(s_a[1]), 32'hc100);
            chk("dma_first_active", 32'(s_act), 1);
         end
         if (j == 10) begin
            chk("dma_ext_rd_adr", 32'(s_a[2]), 32'hc10a);
            chk("dma_ext_rd_din", 32'(s_din4), 32'hff);
         end
         if (j == 11) begin
            chk("dma_int_rd_adr", 32'(s_a[3]), 32'hc10b);
            chk("dma_int_rd_rd_n", 32'(s_rd[3]), 0);
         end
         if (j == 12) begin
            chk("dma_ext_wr_wr_n", 32'(s_wr[3]), 1);
            chk("dma_ext_wr_oe", 32'(s_oe[3]), 0);
         end
         if (j == DmaLen - 1) chk("dma_last_adr", 32'(s_a[4]), 32'hc19f);
      end
      mcycle(0, 16'h0000, 8'h00, -1);
      chk("dma_done_active", 32'(s_act), 0);
      chk("dma_oam_count", 32'(oam_cnt), 160);
      chk("dma_oam_last", 32'(oam_last), 159);

      mcycle(2, 16'hff46, 8'hfe, -1);
      mcycle(0, 16'h0000, 8'h00, -1);
      for (int j = 0; j <= 50; j++) begin
         if (j == 50) mcycle(2, 16'hff46, 8'h80, -1);
         else mcycle(0, 16'h0000, 8'h00, -1);
         if (j == 0) chk("remap_first_adr", 32'(s_a[1]), 32'hde00);
         if (j == 50) chk("restart_byte_adr", 32'(s_a[1]), 32'hde32);
      end
      mcycle(0, 16'h0000, 8'h00, -1);
      chk("restart_start_active", 32'(s_act), 1);
      chk("restart_start_rd_n", 32'(s_rd[2]), 1);
      mcycle(0, 16'h0000, 8'h00, -1);
      chk("restart_first_adr", 32'(s_a[1]), 32'h8000);
      repeat (20) mcycle(0, 16'h0000, 8'h00, -1);

      n_reset = 1'b0;
      bus_quiet();
      #2;
      chk("midrst_dma_active", 32'(bus.dma_active), 0);
      chk("midrst_oam_we", 32'(bus.oam_we), 0);
      chk("midrst_pin_rd_n", 32'(bus.pin_rd_n), 1);
      chk("midrst_pin_a", 32'(bus.pin_a), 0);
      repeat (3) @(posedge clk);
      #1 n_reset = 1'b1;

      for (int k = 0; k < 700; k++) begin
         r   = int'($urandom_range(0, 99));
         op  = (r < 30) ? 0 : (r < 65) ? 1 : 2;
         adr = ($urandom_range(0, 3) == 0) ? 16'hfe00 + 16'($urandom_range(0, 511))
                                            : 16'($urandom);
         dat = 8'($urandom);
         if (op == 2 && $urandom_range(0, 29) == 0) begin
            adr = 16'hff46;
            if ($urandom_range(0, 2) == 0) dat = 8'hfe + 8'($urandom_range(0, 1));
         end
         mcycle(op, adr, dat, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
